// File: rtl/mmio_ctrl_if.sv
// Data-memory-side bus between the CPU and the MMIO controller.
// The CPU side drives address, store data and strobes; the controller returns load data and the page hit.
interface mmio_ctrl_if #(
    parameter int unsigned DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] wrData;
    logic             we;
    logic             re;
    logic [DBITS-1:0] rdData;
    logic             ioHit;

    modport master (output addr, wrData, we, re, input rdData, ioHit);
    modport slave  (input addr, wrData, we, re, output rdData, ioHit);
endinterface

// File: rtl/mmio_ctrl.sv
// I/O-page controller: HEX/LEDR/LEDG output registers, debounced KEY/SW inputs,
// sticky key-press flags and a combinational load path so LW completes in one cycle.
module mmio_ctrl #(
    parameter int unsigned    DBITS           = 32,
    parameter int unsigned    DEBOUNCE_CYCLES = 100000,
    parameter int unsigned    CNT_BITS        = 17,
    parameter logic [DBITS-1:0] ADDR_HEX      = 32'hF0000000,
    parameter logic [DBITS-1:0] ADDR_LEDR     = 32'hF0000004,
    parameter logic [DBITS-1:0] ADDR_LEDG     = 32'hF0000008,
    parameter logic [DBITS-1:0] ADDR_KEY      = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SW       = 32'hF0000014
) (
    input  logic        clk,
    input  logic        reset,
    mmio_ctrl_if.slave  bus,
    input  logic [3:0]  KEY,
    input  logic [9:0]  SW,
    output logic [9:0]  LEDR,
    output logic [7:0]  LEDG,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3
);
    localparam int unsigned NIN = 14;

    logic [15:0]         hex_reg;
    logic [9:0]          ledr_reg;
    logic [7:0]          ledg_reg;
    logic [NIN-1:0]      sync1, sync2, deb, deb_nxt;
    logic [CNT_BITS-1:0] cnt     [NIN];
    logic [CNT_BITS-1:0] cnt_nxt [NIN];
    logic [3:0]          key_edge, key_rise;
    logic                key_clr;
    logic                unused_wrdata;

    assign unused_wrdata = ^bus.wrData[DBITS-1:16];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Per-bit debounce: the counter runs only while the synced bit disagrees with the debounced bit.
    always_comb begin
        deb_nxt = deb;
        for (int i = 0; i < NIN; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != deb[i]) begin
                if (cnt[i] == CNT_BITS'(DEBOUNCE_CYCLES - 1))
                    deb_nxt[i] = sync2[i];
                else
                    cnt_nxt[i] = cnt[i] + CNT_BITS'(1);
            end
        end
    end

    // Reading KEY clears every flag it showed; a press landing on the same edge survives.
    assign key_rise = deb_nxt[3:0] & ~deb[3:0];
    assign key_clr  = bus.re && (bus.addr == ADDR_KEY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            key_edge <= '0;
            for (int i = 0; i < NIN; i++) cnt[i] <= '0;
        end else begin
            sync1    <= {SW, ~KEY};
            sync2    <= sync1;
            deb      <= deb_nxt;
            key_edge <= (key_clr ? 4'b0000 : key_edge) | key_rise;
            for (int i = 0; i < NIN; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_reg  <= '0;
            ledr_reg <= '0;
            ledg_reg <= '0;
        end else if (bus.we) begin
            case (bus.addr)
                ADDR_HEX:  hex_reg  <= bus.wrData[15:0];
                ADDR_LEDR: ledr_reg <= bus.wrData[9:0];
                ADDR_LEDG: ledg_reg <= bus.wrData[7:0];
                default: ;
            endcase
        end
    end

    assign bus.ioHit = (bus.addr[DBITS-1 -: 4] == 4'hF);

    always_comb begin
        bus.rdData = '0;
        if (bus.re) begin
            case (bus.addr)
                ADDR_HEX:  bus.rdData = DBITS'(hex_reg);
                ADDR_LEDR: bus.rdData = DBITS'(ledr_reg);
                ADDR_LEDG: bus.rdData = DBITS'(ledg_reg);
                ADDR_KEY:  bus.rdData = DBITS'({key_edge, deb[3:0]});
                ADDR_SW:   bus.rdData = DBITS'(deb[13:4]);
                default: ;
            endcase
        end
    end

    assign LEDR = ledr_reg;
    assign LEDG = ledg_reg;
    assign HEX0 = seg7(hex_reg[3:0]);
    assign HEX1 = seg7(hex_reg[7:4]);
    assign HEX2 = seg7(hex_reg[11:8]);
    assign HEX3 = seg7(hex_reg[15:12]);
endmodule

// File: tb/tb_mmio_ctrl.sv
// Bench for mmio_ctrl with a short debounce window; expectations queue up when
// stimulus is applied and are retired against the DUT outputs mid-cycle.
module tb_mmio_ctrl;
    localparam logic [31:0] A_HEX  = 32'hF0000000;
    localparam logic [31:0] A_LEDR = 32'hF0000004;
    localparam logic [31:0] A_LEDG = 32'hF0000008;
    localparam logic [31:0] A_KEY  = 32'hF0000010;
    localparam logic [31:0] A_SW   = 32'hF0000014;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [7:0] LEDG;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    mmio_ctrl_if bus ();

    mmio_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_BITS(3)) dut (
        .clk(clk), .reset(reset), .bus(bus), .KEY(KEY), .SW(SW),
        .LEDR(LEDR), .LEDG(LEDG), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic pop(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: got 0x%08h expected none", got);
        end else begin
            e = sb.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a; bus.wrData = d; bus.we = 1'b1;
        cyc();
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus.addr = a; bus.re = 1'b1;
        push(tag, exp);
        @(negedge clk);
        pop(bus.rdData);
        cyc();
        bus.re = 1'b0;
    endtask

    task automatic leds(input logic [9:0] r, input logic [7:0] g, input string tag);
        push({tag, "_ledr"}, 32'(r));
        push({tag, "_ledg"}, 32'(g));
        @(negedge clk);
        pop(32'(LEDR));
        pop(32'(LEDG));
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; KEY = 4'hF; SW = '0;
        bus.addr = '0; bus.wrData = '0; bus.we = 1'b0; bus.re = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();

        // reset state
        push("rst_hex0", 32'h40); push("rst_hex3", 32'h40);
        @(negedge clk);
        pop(32'(HEX0)); pop(32'(HEX3));
        cyc();
        leds(10'h0, 8'h0, "rst");
        rd(A_HEX, 32'h0, "rst_rd_hex");
        rd(A_KEY, 32'h0, "rst_rd_key");

        // HEX register and decode
        wr(A_HEX, 32'h00001A3F);
        push("hex0", 32'b0001110); push("hex1", 32'b0110000);
        push("hex2", 32'b0001000); push("hex3", 32'b1111001);
        @(negedge clk);
        pop(32'(HEX0)); pop(32'(HEX1)); pop(32'(HEX2)); pop(32'(HEX3));
        cyc();
        rd(A_HEX, 32'h00001A3F, "rd_hex");
        bus.addr = A_HEX; bus.re = 1'b0;
        push("re0_gate", 32'h0);
        @(negedge clk);
        pop(bus.rdData);
        cyc();

        // LED registers, non-I/O store and ignored F-page stores
        wr(A_LEDR, 32'hFFFFFFFF);
        wr(A_LEDG, 32'hFFFFFFFF);
        leds(10'h3FF, 8'hFF, "led_all");
        rd(A_LEDR, 32'h3FF, "rd_ledr");
        rd(A_LEDG, 32'hFF, "rd_ledg");
        bus.addr = 32'h00000004; bus.wrData = 32'h0; bus.we = 1'b1;
        push("iohit_low", 32'h0);
        @(negedge clk);
        pop(32'(bus.ioHit));
        cyc();
        bus.we = 1'b0;
        wr(A_KEY, 32'h0);
        wr(A_SW, 32'h0);
        wr(32'hF0000020, 32'h0);
        leds(10'h3FF, 8'hFF, "led_kept");
        bus.addr = 32'hF0000020; bus.re = 1'b1;
        push("unmapped_rd", 32'h0); push("iohit_high", 32'h1);
        @(negedge clk);
        pop(bus.rdData); pop(32'(bus.ioHit));
        cyc();
        bus.re = 1'b0;
        rd(32'h00000010, 32'h0, "nonio_rd");

        // simultaneous store and load: load shows the old value
        bus.addr = A_LEDG; bus.wrData = 32'h5A; bus.we = 1'b1; bus.re = 1'b1;
        push("we_re_old", 32'hFF);
        @(negedge clk);
        pop(bus.rdData);
        cyc();
        bus.we = 1'b0; bus.re = 1'b0;
        rd(A_LEDG, 32'h5A, "we_re_new");

        // KEY[0] press: visible after 6 edges, flag clears on read
        KEY[0] = 1'b0;
        for (int i = 0; i <= 6; i++) rd(A_KEY, (i == 6) ? 32'h11 : 32'h0, "key0_press");
        rd(A_KEY, 32'h01, "key0_cleared");
        KEY[0] = 1'b1;
        for (int i = 0; i <= 6; i++) rd(A_KEY, (i < 6) ? 32'h01 : 32'h0, "key0_release");

        // glitches shorter than the window are filtered
        KEY[1] = 1'b0;
        cyc(); cyc(); cyc();
        KEY[1] = 1'b1;
        for (int i = 0; i < 6; i++) rd(A_KEY, 32'h0, "key1_glitch");
        for (int i = 0; i < 8; i++) begin
            SW[5] = ((i / 2) % 2) == 0;
            rd(A_SW, 32'h0, "sw5_bounce");
        end
        cyc(); cyc(); cyc(); cyc();
        SW[5] = 1'b1;
        for (int i = 0; i <= 6; i++) rd(A_SW, (i == 6) ? 32'h020 : 32'h0, "sw5_hold");

        // a press landing on the clearing read survives the clear
        KEY[1] = 1'b0;
        cyc();
        KEY[2] = 1'b0;
        for (int i = 0; i <= 6; i++)
            rd(A_KEY, (i < 5) ? 32'h0 : ((i == 5) ? 32'h22 : 32'h46), "key2_race");
        rd(A_KEY, 32'h06, "key2_after");
        KEY = 4'hF;
        for (int i = 0; i < 8; i++) cyc();
        rd(A_KEY, 32'h0, "keys_released");

        // reset mid-debounce
        wr(A_LEDR, 32'h155);
        leds(10'h155, 8'h5A, "pre_rst");
        KEY[3] = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        reset = 1'b1;
        #1;
        push("mid_rst_ledr", 32'h0);
        pop(32'(LEDR));
        cyc();
        reset = 1'b0;
        for (int i = 0; i <= 6; i++) rd(A_KEY, (i == 6) ? 32'h88 : 32'h0, "key3_post_rst");

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_leftover: got %0d expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mmio_ctrl.md
Name: mmio_ctrl

Overview:
- Memory-mapped I/O controller for the single-cycle CPU; sits on the data-memory bus beside DMem.
- Decodes the 0xF000_00xx I/O page and owns the HEX, LEDR and LEDG output registers.
- Synchronizes and debounces KEY and SW, and keeps sticky key-press flags.
- Read data is combinational, so a LW completes in the same cycle; writes commit at posedge clk.

Parameters:
DBITS, 32, bus data/address width
DEBOUNCE_CYCLES, 100000, consecutive stable cycles before a debounced input changes
CNT_BITS, 17, width of each debounce counter (must hold DEBOUNCE_CYCLES)
ADDR_HEX, 32'hF0000000, HEX display register
ADDR_LEDR, 32'hF0000004, red LED register
ADDR_LEDG, 32'hF0000008, green LED register
ADDR_KEY, 32'hF0000010, key state/edge register (read-only)
ADDR_SW, 32'hF0000014, switch state register (read-only)

Ports:
clk  in  1  system clock (PLL c0)
reset  in  1  asynchronous, active-high reset
addr  in  32  bus address from ALU result
wrData  in  32  store data (regout2)
we  in  1  store strobe (SW instruction)
re  in  1  load strobe (LW instruction)
rdData  out  32  load data; valid combinationally while re=1
ioHit  out  1  addr[31:28]==4'hF; top uses it to block DMem writes and select rdData
KEY  in  4  raw board keys, active-low
SW  in  10  raw board switches
LEDR  out  10  red LEDs
LEDG  out  8  green LEDs
HEX0,HEX1,HEX2,HEX3  out  7 each  seven-segment displays, active-low, bit i = segment i (a=0 … g=6)

Behaviour:
- Reset (async): hexReg=0, ledrReg=0, ledgReg=0, sync flops=0 (keys read as released), debounced key/sw=0, counters=0, keyEdge=0. HEX0..3 therefore show "0" (7'b1000000); LEDs are off.
- Synchronizer: two flops on ~KEY and on SW.
- Debounce: one counter per bit (14 in total).
  - When the synced bit differs from the debounced bit, the counter increments; otherwise the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced bit flips on that edge and the counter clears.
  - Total latency from raw change to debounced change is 2+DEBOUNCE_CYCLES edges.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no change.
- keyEdge[i]: set on the edge where debounced key i goes 0→1 (press). It is sticky until cleared.
  - Clear: re=1 with addr==ADDR_KEY clears, at posedge, the bits that read as 1 in that cycle.
  - A new press on the same edge as a clear wins: the bit stays 1.
  - Releases never set the flag.
- Writes: we=1 and an exact address match commit at posedge clk.
  - hexReg <= wrData[15:0]; ledrReg <= wrData[9:0]; ledgReg <= wrData[7:0].
  - Writes to KEY, SW or unmapped F-page addresses are ignored.
  - Writes with addr[31:28]!=F are ignored and ioHit=0.
- Reads (combinational, gated by re; rdData=0 when re=0):
  - HEX → {16'b0,hexReg}; LEDR → {22'b0,ledrReg}; LEDG → {24'b0,ledgReg}.
  - KEY → {24'b0,keyEdge,keyState}; SW → {22'b0,swState}.
  - Unmapped or non-I/O address → 0.
- The same instruction cannot assert we and re together. If both are asserted, the write commits and rdData still shows the pre-write value.
- Display: HEXn = 7-segment decode of hexReg[4n+3:4n], hex digits 0-F. Examples: 0=1000000, 1=1111001, 3=0110000, A=0001000, F=0001110.
- LEDR/LEDG are driven directly from their registers.
- Reset asserted mid-debounce: counters and debounced state return to 0 immediately, and no edge flag is set on release of reset.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then write 0x00001A3F to ADDR_HEX → next cycle HEX3=1111001, HEX2=0001000, HEX1=0110000, HEX0=0001110; LW returns 0x00001A3F.
- Write 0xFFFFFFFF to LEDR, then to LEDG → LEDR=10'h3FF, LEDG=8'hFF; read-back values 0x3FF and 0xFF; a write to 0x00000004 leaves the LEDs unchanged and ioHit=0.
- Hold KEY[0]=0 → KEY read is 0x00 for 5 edges and 0x11 after the 6th; a read clears it; the next read is 0x01; release KEY → 0x00 after 6 edges, edge flag stays 0.
- KEY[1] pulsed low for 3 cycles, and SW[5] toggled with 2-cycle bounces → KEY and SW reads stay 0. SW[5] then held high 6+ cycles → SW read is 0x020.
- Read of ADDR_KEY in the same cycle keyEdge[2] is set by a new press → bit 6 remains set after the clear.
- Assert reset while KEY[3] is mid-debounce (counter=2) and LEDR=0x155 → LEDR=0, counters 0; after deassert, KEY[3] needs a full 4 stable cycles (plus sync) to register.
